// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Module   : sram_arb_pkg
// Purpose  : Shared types and constants for the two-port 16-bit SRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sram_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] HALF_LO = 2'b00;
  localparam logic [1:0] HALF_HI = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_GAP  = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sram_arb_rr.sv
// ============================================================================
// Module   : sram_arb_rr
// Purpose  : Two-way round-robin picker; the port not granted last wins ties.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  assign grant_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

`default_nettype wire

// File: rtl/sram_arb.sv
// ============================================================================
// Module   : sram_arb
// Purpose  : Shares one 16-bit SRAM between two 32-bit requesters (low then
//            high half). Optional half-word write strobes: SRAM_ARB_HSTB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int SRAM_CYC = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_0,
  input  logic        rw_0,
  input  logic [31:0] addr_0,
  input  logic [31:0] wdata_0,
  output logic        ack_0,
  output logic [31:0] rdata_0,
  input  logic        req_1,
  input  logic        rw_1,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_1,
  output logic        ack_1,
  output logic [31:0] rdata_1,
`ifdef SRAM_ARB_HSTB_EN
  input  logic [1:0]  hstb_0,
  input  logic [1:0]  hstb_1,
`endif
  output logic        sram_valid,
  output logic        sram_rw,
  output logic [31:0] sram_addr,
  output logic [15:0] sram_dtw,
  input  logic [15:0] sram_din
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               port_q, port_d;
  logic               rw_q, rw_d;
  logic [31:2]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         grant_w;
  logic               cnt_last_w;
  logic               skip_lo_w, skip_hi_w;
  logic               unused_addr_lsbs;

  // Byte offset within the word never reaches the SRAM.
  assign unused_addr_lsbs = ^{addr_0[1:0], addr_1[1:0]};

  sram_arb_rr u_rr (
    .req_i   ({req_1, req_0}),
    .last_i  (last_q),
    .grant_o (grant_w)
  );

  assign cnt_last_w = (cnt_q == CNT_W'(SRAM_CYC - 1));

`ifdef SRAM_ARB_HSTB_EN
  logic [1:0] hstb_q, hstb_d;
  assign skip_lo_w = rw_q & ~hstb_q[0];
  assign skip_hi_w = rw_q & ~hstb_q[1];
`else
  assign skip_lo_w = 1'b0;
  assign skip_hi_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_ARB_HSTB_EN
      hstb_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      port_q  <= port_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_ARB_HSTB_EN
      hstb_q  <= hstb_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    port_d     = port_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
`ifdef SRAM_ARB_HSTB_EN
    hstb_d     = hstb_q;
`endif
    sram_valid = 1'b0;
    sram_rw    = 1'b0;
    sram_addr  = '0;
    sram_dtw   = '0;
    ack_0      = 1'b0;
    ack_1      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|grant_w) begin
          port_d  = grant_w[1];
          last_d  = grant_w[1];
          rw_d    = grant_w[1] ? rw_1 : rw_0;
          addr_d  = grant_w[1] ? addr_1[31:2] : addr_0[31:2];
          wdata_d = grant_w[1] ? wdata_1 : wdata_0;
`ifdef SRAM_ARB_HSTB_EN
          hstb_d  = grant_w[1] ? hstb_1 : hstb_0;
`endif
          cnt_d   = '0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (!skip_lo_w) begin
          sram_valid = 1'b1;
          sram_rw    = rw_q;
          sram_addr  = {addr_q, HALF_LO};
          sram_dtw   = rw_q ? wdata_q[15:0] : 16'h0000;
        end
        if (cnt_last_w) begin
          cnt_d   = '0;
          state_d = S_GAP;
          if (!rw_q) rdata_d[15:0] = sram_din;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: state_d = S_HI;
      S_HI: begin
        if (!skip_hi_w) begin
          sram_valid = 1'b1;
          sram_rw    = rw_q;
          sram_addr  = {addr_q, HALF_HI};
          sram_dtw   = rw_q ? wdata_q[31:16] : 16'h0000;
        end
        if (cnt_last_w) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!rw_q) rdata_d[31:16] = sram_din;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        ack_0   = ~port_q;
        ack_1   = port_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_0 = rdata_q;
  assign rdata_1 = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arb.sv
// ============================================================================
// Module   : tb_sram_arb
// Purpose  : Self-checking bench for sram_arb against a word-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_arb;

  localparam int C = 3;
`ifdef SRAM_ARB_HSTB_EN
  localparam bit HSTB_ON = 1'b1;
`else
  localparam bit HSTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_0, rw_0, req_1, rw_1;
  logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
  logic [1:0]  hstb_0, hstb_1;
  logic        ack_0, ack_1;
  logic [31:0] rdata_0, rdata_1;
  logic        sram_valid, sram_rw;
  logic [31:0] sram_addr;
  logic [15:0] sram_dtw, sram_din;

  logic [15:0] dev_mem [0:511];
  logic [15:0] ref_mem [0:511];
  int          n_chk = 0;
  int          n_err = 0;
  int          last_m;
  logic [1:0]  rq;

  always #5 clk = ~clk;

  sram_arb #(.SRAM_CYC(C)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_0      (req_0),
    .rw_0       (rw_0),
    .addr_0     (addr_0),
    .wdata_0    (wdata_0),
    .ack_0      (ack_0),
    .rdata_0    (rdata_0),
    .req_1      (req_1),
    .rw_1       (rw_1),
    .addr_1     (addr_1),
    .wdata_1    (wdata_1),
    .ack_1      (ack_1),
    .rdata_1    (rdata_1),
`ifdef SRAM_ARB_HSTB_EN
    .hstb_0     (hstb_0),
    .hstb_1     (hstb_1),
`endif
    .sram_valid (sram_valid),
    .sram_rw    (sram_rw),
    .sram_addr  (sram_addr),
    .sram_dtw   (sram_dtw),
    .sram_din   (sram_din)
  );

  // 16-bit SRAM device: combinational read, write applied once per cycle.
  assign sram_din = dev_mem[sram_addr[9:1]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (sram_valid && sram_rw) dev_mem[sram_addr[9:1]] = sram_dtw;
  endtask

  task automatic tick_idle();
    tick();
    check("idle_bus", {sram_valid, sram_rw, sram_addr, sram_dtw}, 64'h0);
    check("idle_ack", {ack_1, ack_0}, 2'b00);
  endtask

  task automatic rnd_port(input int p);
    if (p == 0) begin
      rw_0 = 1'($urandom); addr_0 = $urandom; wdata_0 = $urandom; hstb_0 = 2'($urandom);
    end else begin
      rw_1 = 1'($urandom); addr_1 = $urandom; wdata_1 = $urandom; hstb_1 = 2'($urandom);
    end
  endtask

  // Entered at the falling edge of an IDLE cycle with requests applied;
  // returns at the falling edge of the ack cycle.
  task automatic run_txn(input bit drop);
    int          g;
    bit          w, sk_lo, sk_hi, ph, sk;
    logic [31:0] a, d, pa;
    logic [15:0] pd;
    logic [1:0]  hs;
    logic [8:0]  il, ih;
    if (req_0 && req_1) g = (last_m == 0) ? 1 : 0;
    else                g = req_1 ? 1 : 0;
    if (g == 0) begin w = rw_0; a = addr_0; d = wdata_0; hs = hstb_0; end
    else        begin w = rw_1; a = addr_1; d = wdata_1; hs = hstb_1; end
    sk_lo  = HSTB_ON && w && !hs[0];
    sk_hi  = HSTB_ON && w && !hs[1];
    il     = {a[9:2], 1'b0};
    ih     = {a[9:2], 1'b1};
    last_m = g;
    for (int cyc = 1; cyc <= 2*C+2; cyc++) begin
      tick();
      if (cyc == 1) rnd_port(g);
      ph = (cyc <= C) || (cyc > C+1 && cyc <= 2*C+1);
      if (ph) begin
        sk = (cyc <= C) ? sk_lo : sk_hi;
        pa = {a[31:2], (cyc <= C) ? 2'b00 : 2'b10};
        pd = (cyc <= C) ? d[15:0] : d[31:16];
        if (sk) check("skip_valid", sram_valid, 1'b0);
        else    check("phase_bus", {sram_valid, sram_rw, sram_addr, w ? sram_dtw : 16'h0},
                      {1'b1, w, pa, w ? pd : 16'h0});
      end else begin
        check("gap_bus", {sram_valid, sram_rw, sram_addr, sram_dtw}, 64'h0);
      end
      check("ack", {ack_1, ack_0}, (cyc == 2*C+2) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00);
    end
    if (!w) begin
      check((g == 0) ? "rdata_0" : "rdata_1", (g == 0) ? rdata_0 : rdata_1, {ref_mem[ih], ref_mem[il]});
    end else begin
      if (!sk_lo) ref_mem[il] = d[15:0];
      if (!sk_hi) ref_mem[ih] = d[31:16];
    end
    if (drop) begin
      if (g == 0) req_0 = 1'b0; else req_1 = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_0 = 1'b0; rw_0 = 1'b0; addr_0 = '0; wdata_0 = '0; hstb_0 = 2'b11;
    req_1 = 1'b0; rw_1 = 1'b0; addr_1 = '0; wdata_1 = '0; hstb_1 = 2'b11;
    last_m = 1;
    for (int i = 0; i < 512; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end

    @(negedge clk);
    check("reset_bus", {sram_valid, sram_rw, sram_addr, sram_dtw}, 64'h0);
    check("reset_ack", {ack_1, ack_0}, 2'b00);
    check("reset_rdata", {rdata_1, rdata_0}, 64'h0);

    // Port 0 requests and withdraws before it can be granted.
    req_0 = 1'b1;
    tick();
    req_0 = 1'b0;
    req_1 = 1'b1; rw_1 = 1'b0; addr_1 = $urandom;
    reset_n = 1'b1;
    run_txn(1'b1);

    // Port 0 read of 0x10 with known SRAM contents.
    dev_mem[8] = 16'h1234; ref_mem[8] = 16'h1234;
    dev_mem[9] = 16'hABCD; ref_mem[9] = 16'hABCD;
    req_0 = 1'b1; rw_0 = 1'b0; addr_0 = 32'h0000_0010;
    tick_idle();
    run_txn(1'b1);
    check("read_known", rdata_0, 32'hABCD_1234);

    // Port 1 write at an unaligned byte address.
    req_1 = 1'b1; rw_1 = 1'b1; addr_1 = 32'h0000_0103; wdata_1 = 32'hDEAD_BEEF; hstb_1 = 2'b11;
    tick_idle();
    run_txn(1'b1);

    // High-half-only strobed write.
    req_0 = 1'b1; rw_0 = 1'b1; addr_0 = 32'h0000_0200; wdata_0 = 32'h5555_AAAA; hstb_0 = 2'b10;
    tick_idle();
    run_txn(1'b1);

    // Reset in the second HI cycle of a read, then the same request reruns.
    req_0 = 1'b1; rw_0 = 1'b0; addr_0 = 32'h0000_0044;
    tick_idle();
    for (int i = 0; i < C+3; i++) tick();
    reset_n = 1'b0;
    #1;
    check("abort_bus", {sram_valid, sram_rw, sram_addr, sram_dtw}, 64'h0);
    check("abort_ack", {ack_1, ack_0}, 2'b00);
    check("abort_rdata", rdata_0, 32'h0);
    @(negedge clk);
    check("abort_hold_ack", {ack_1, ack_0}, 2'b00);
    reset_n = 1'b1;
    last_m = 1;
    run_txn(1'b1);

    // Both ports requesting continuously.
    req_0 = 1'b1; req_1 = 1'b1;
    rnd_port(0); rnd_port(1);
    for (int k = 0; k < 6; k++) begin
      tick_idle();
      run_txn(1'b0);
    end
    req_0 = 1'b0; req_1 = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      rq = 2'($urandom_range(1, 3));
      req_0 = rq[0]; req_1 = rq[1];
      rnd_port(0); rnd_port(1);
      tick_idle();
      run_txn(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter SRAM_CYC, default 3, giving the number of cycles sram_valid is held per 16-bit SRAM phase (legal 1..15).
REQ-002 SHALL have ports: clk in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have, per requester p in {0,1}: req_p in 1 (request); rw_p in 1 (1 = write); addr_p in 32 (byte address); wdata_p in 32 (write data); ack_p out 1 (one-cycle completion pulse); rdata_p out 32 (read data, valid with ack_p).
REQ-004 SHALL have SRAM-side ports: sram_valid out 1; sram_rw out 1 (1 = write); sram_addr out 32; sram_dtw out 16 (data to write); sram_din in 16 (data read from SRAM).

Function
REQ-005 SHALL share one 16-bit EXT_SRAM between two 32-bit requesters, splitting each word into a low-half phase then a high-half phase.
REQ-006 SHALL address the low half at {addr[31:2],2'b00} and the high half at {addr[31:2],2'b10}; addr[1:0] is ignored.
REQ-007 SHALL use FSM states IDLE -> LO -> GAP -> HI -> DONE -> IDLE.
REQ-008 In IDLE with any req asserted, SHALL grant one port, latch its rw/addr/wdata and enter LO on the next edge.
REQ-009 SHALL arbitrate round-robin: when both ports request, grant the port not granted last; after reset, port 0 has priority.
REQ-010 In LO and HI, SHALL drive sram_valid=1 with constant sram_rw/sram_addr/sram_dtw for exactly SRAM_CYC cycles, counted by a 4-bit phase counter.
REQ-011 On a read, SHALL capture sram_din on the last cycle of LO into rdata[15:0] and on the last cycle of HI into rdata[31:16].
REQ-012 On a write, sram_dtw SHALL be wdata[15:0] in LO and wdata[31:16] in HI.
REQ-013 GAP and DONE SHALL each last one cycle with sram_valid=0, sram_rw=0, sram_addr=0 and sram_dtw=0.
REQ-014 In DONE, SHALL pulse ack of the granted port for exactly one cycle, with rdata valid in that cycle (reads only; rdata unspecified for writes).
REQ-015 SHALL take 2*SRAM_CYC+3 cycles from the grant edge to the ack cycle inclusive (9 at default), with no overlap between transactions.
REQ-016 Requesters SHALL hold req until ack; the block SHALL ignore req, rw, addr and wdata changes after grant.
REQ-017 A requester deasserting req before grant SHALL be treated as never having requested.
REQ-018 The block SHALL accept back-to-back requests: a req still asserted in the ack cycle is a new request, evaluated in the following IDLE cycle.

Reset
REQ-019 Asserting reset_n low SHALL asynchronously force state IDLE, counter 0, last-grant to port 1 (so port 0 wins first), and all outputs 0 (sram_valid, sram_rw, sram_addr, sram_dtw, ack_p, rdata_p).
REQ-020 Reset mid-transaction SHALL abort it with no ack; the aborted request SHALL be re-arbitrated from scratch after release.

Configuration
REQ-021 SHALL compile in half-word strobes when macro SRAM_ARB_HSTB_EN is defined, adding hstb_p in 2 per port.
REQ-022 With SRAM_ARB_HSTB_EN defined, a write SHALL skip LO when hstb[0]=0 and skip HI when hstb[1]=0.
REQ-023 A skipped phase SHALL keep its paired GAP/DONE cycle but drive sram_valid=0 for its duration; a write with hstb=2'b00 SHALL complete with ack and no SRAM activity.
REQ-024 Reads SHALL always perform both phases.
REQ-025 Without SRAM_ARB_HSTB_EN, no hstb ports SHALL exist and both phases SHALL always run.

Structure
REQ-026 Package sram_arb_pkg SHALL hold the FSM state encoding, half offsets 2'b00/2'b10, and the counter width.
REQ-027 Sub-module sram_arb_rr SHALL implement the 2-way round-robin picker (inputs: req[1:0], last; outputs: grant[1:0]).

Verification
REQ-028 Port 0 reads addr 32'h0000_0010 with sram_din=16'h1234 in LO and 16'hABCD in HI -> ack_0 9 cycles after grant with rdata_0=32'hABCD1234, sram_addr 32'h10 then 32'h12.
REQ-029 Port 1 writes 32'hDEAD_BEEF at 32'h0000_0103 -> 3 cycles of BEEF at 32'h100, 1 idle cycle, 3 cycles of DEAD at 32'h102, then ack_1.
REQ-030 Both ports request continuously -> grants alternate 0,1,0,1 and each ack pulses exactly once per transaction.
REQ-031 reset_n pulled low in cycle 2 of HI -> sram_valid=0 immediately, no ack; after release the same request completes normally.
REQ-032 With SRAM_ARB_HSTB_EN, write hstb=2'b10 of 32'h5555_AAAA -> only 16'h5555 written at the high address, ack after 9 cycles.
REQ-033 Port 0 drops req before grant while port 1 requests -> port 1 granted, no ack_0.
